// File: rtl/router_pkg.sv
// Shared router definitions: flit type codes, default widths
// and flit field slice helpers.
package router_pkg;

  localparam int DATAW_D = 64;
  localparam int TYPEW_D = 3;
  localparam int VCHW_D  = 1;
  localparam int FLITW_D = TYPEW_D + DATAW_D;

  typedef enum logic [2:0] {
    FT_NONE     = 3'd0,
    FT_HEAD     = 3'd1,
    FT_TAIL     = 3'd2,
    FT_DATA     = 3'd3,
    FT_HEADTAIL = 3'd4
  } flit_type_e;

  function automatic logic [TYPEW_D-1:0] flit_type(
    input logic [FLITW_D-1:0] f
  );
    return f[FLITW_D-1 -: TYPEW_D];
  endfunction

  function automatic logic [DATAW_D-1:0] flit_payload(
    input logic [FLITW_D-1:0] f
  );
    return f[DATAW_D-1:0];
  endfunction

endpackage

// File: rtl/link_outbuf_if.sv
// Mux-side flit stream, link-side flit stream, credit return
// and status of the output link buffer.
interface link_outbuf_if #(
  parameter int DATAW = router_pkg::DATAW_D,
  parameter int TYPEW = router_pkg::TYPEW_D,
  parameter int VCHW  = router_pkg::VCHW_D,
  parameter int DEPTH = 4
);
  localparam int FW   = TYPEW + DATAW;
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [FW-1:0]   idata;
  logic            ivalid;
  logic [VCHW-1:0] ivch;
  logic            iready;
  logic [FW-1:0]   odata;
  logic            ovalid;
  logic [VCHW-1:0] ovch;
  logic            icredit;
  logic [VCHW-1:0] icredit_vch;
  logic            oerr;
  logic [CNTW-1:0] ocount;

  modport slave (
    input  idata, ivalid, ivch, icredit, icredit_vch,
    output iready, odata, ovalid, ovch, oerr, ocount
  );

  modport master (
    output idata, ivalid, ivch, icredit, icredit_vch,
    input  iready, odata, ovalid, ovch, oerr, ocount
  );

endinterface

// File: rtl/flit_fifo.sv
// Shared synchronous flit FIFO; pointers wrap modulo DEPTH,
// push/pop are ignored when full/empty respectively.
module flit_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q + AW'(do_push);
    rptr_d = rptr_q + AW'(do_pop);
    cnt_d  = cnt_q + (AW+1)'(do_push)
           - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/link_outbuf.sv
// Output link buffer: shared FIFO, per-VC credit gating,
// registered link outputs and per-VC packet framing checker.
module link_outbuf
  import router_pkg::*;
#(
  parameter int DATAW   = DATAW_D,
  parameter int TYPEW   = TYPEW_D,
  parameter int VCHW    = VCHW_D,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input logic         clk,
  input logic         rst_,
  link_outbuf_if.slave l
);
  localparam int NVC  = 1 << VCHW;
  localparam int FW   = TYPEW + DATAW;
  localparam int EW   = FW + VCHW;
  localparam int CW   = $clog2(CREDITS + 1);
  localparam int CNTW = $clog2(DEPTH) + 1;

  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(FT_HEAD);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(FT_TAIL);
  localparam logic [TYPEW-1:0] T_DATA = TYPEW'(FT_DATA);
  localparam logic [TYPEW-1:0] T_HT   = TYPEW'(FT_HEADTAIL);

  logic [EW-1:0]           head;
  logic [VCHW-1:0]         head_vch;
  logic [FW-1:0]           head_flit;
  logic                    full, empty, push, send;
  logic [CNTW-1:0]         count;
  logic [NVC-1:0]          inc_v, dec_v;
  logic [NVC-1:0][CW-1:0]  cred_q, cred_d;
  logic [NVC-1:0]          open_q, open_d;
  logic                    err_q, err_d;
  logic                    ovalid_q, ovalid_d;
  logic [FW-1:0]           odata_q, odata_d;
  logic [VCHW-1:0]         ovch_q, ovch_d;
  logic [TYPEW-1:0]        in_type;
  logic                    in_open;

  assign {head_vch, head_flit} = head;
  assign push    = l.ivalid && !full;
  assign send    = !empty && (cred_q[head_vch] != '0);
  assign in_type = l.idata[FW-1 -: TYPEW];
  assign in_open = open_q[l.ivch];

  flit_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .pop   (send),
    .wdata ({l.ivch, l.idata}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (l.icredit) inc_v[l.icredit_vch] = 1'b1;
    if (send)      dec_v[head_vch]      = 1'b1;
  end

  always_comb begin
    cred_d = cred_q;
    open_d = open_q;
    err_d  = err_q;
    // a return that coincides with a send on the same VC nets out
    for (int v = 0; v < NVC; v++) begin
      if (inc_v[v] && !dec_v[v]) begin
        if (cred_q[v] == CW'(CREDITS)) err_d = 1'b1;
        else cred_d[v] = cred_q[v] + 1'b1;
      end else if (dec_v[v] && !inc_v[v]) begin
        cred_d[v] = cred_q[v] - 1'b1;
      end
    end
    if (push) begin
      unique case (1'b1)
        in_type == T_HEAD: begin
          err_d = err_d | in_open;
          open_d[l.ivch] = 1'b1;
        end
        in_type == T_HT: begin
          err_d = err_d | in_open;
          open_d[l.ivch] = 1'b0;
        end
        in_type == T_DATA: begin
          err_d = err_d | !in_open;
        end
        in_type == T_TAIL: begin
          err_d = err_d | !in_open;
          open_d[l.ivch] = 1'b0;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    ovalid_d = send;
    odata_d  = send ? head_flit : '0;
    ovch_d   = send ? head_vch : '0;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cred_q   <= {NVC{CW'(CREDITS)}};
      open_q   <= '0;
      err_q    <= 1'b0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      ovch_q   <= '0;
    end else begin
      cred_q   <= cred_d;
      open_q   <= open_d;
      err_q    <= err_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      ovch_q   <= ovch_d;
    end
  end

  assign l.iready = !full;
  assign l.odata  = odata_q;
  assign l.ovalid = ovalid_q;
  assign l.ovch   = ovch_q;
  assign l.oerr   = err_q;
  assign l.ocount = count;

endmodule

// File: tb/tb_link_outbuf.sv
// Bench for link_outbuf: directed scenarios and random traffic
// checked against a queue-based reference model.
module tb_link_outbuf;
  import router_pkg::*;

  localparam int DATAW   = 64;
  localparam int TYPEW   = 3;
  localparam int VCHW    = 1;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;
  localparam int NVC     = 2;
  localparam int FW      = TYPEW + DATAW;
  localparam int CNTW    = 3;
  localparam int OW      = 1 + VCHW + FW + CNTW + 1 + 1;

  typedef struct packed {
    logic [VCHW-1:0] v;
    logic [FW-1:0]   f;
  } ent_t;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  link_outbuf_if #(
    .DATAW(DATAW), .TYPEW(TYPEW), .VCHW(VCHW), .DEPTH(DEPTH)
  ) l ();

  link_outbuf #(
    .DATAW(DATAW), .TYPEW(TYPEW), .VCHW(VCHW),
    .DEPTH(DEPTH), .CREDITS(CREDITS)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .l    (l)
  );

  ent_t          mq[$];
  int            mcred[NVC];
  bit            mopen[NVC];
  bit            merr;
  bit            msnd;
  logic [OW-1:0] expv, obs, rstv;
  int            total = 0;
  int            bad = 0;

  function automatic logic [FW-1:0] mk(int t, logic [DATAW-1:0] p);
    return {TYPEW'(t), p};
  endfunction

  function automatic logic [DATAW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset;
    mq.delete();
    for (int v = 0; v < NVC; v++) begin
      mcred[v] = CREDITS;
      mopen[v] = 1'b0;
    end
    merr = 1'b0;
    msnd = 1'b0;
    expv = rstv;
  endtask

  task automatic do_reset;
    l.ivalid = 1'b0;
    l.idata = '0;
    l.ivch = '0;
    l.icredit = 1'b0;
    l.icredit_vch = '0;
    #3 rst_ = 1'b0;
    #10 rst_ = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // drive one cycle and advance the reference model over the edge
  task automatic step(input bit vld, input int vch,
                      input logic [FW-1:0] f, input bit cr,
                      input int crv, output bit acc);
    ent_t e;
    int t;
    l.ivalid = vld;
    l.ivch = VCHW'(vch);
    l.idata = f;
    l.icredit = cr;
    l.icredit_vch = VCHW'(crv);
    @(posedge clk);
    msnd = mq.size() > 0 && mcred[mq[0].v] > 0;
    acc = vld && mq.size() < DEPTH;
    e = '0;
    if (msnd) begin
      e = mq.pop_front();
      mcred[e.v] = mcred[e.v] - 1;
    end
    if (cr) begin
      if (mcred[crv] == CREDITS) merr = 1'b1;
      else mcred[crv] = mcred[crv] + 1;
    end
    if (acc) begin
      mq.push_back({VCHW'(vch), f});
      t = int'(f[FW-1 -: TYPEW]);
      case (t)
        1: begin
          if (mopen[vch]) merr = 1'b1;
          mopen[vch] = 1'b1;
        end
        4: begin
          if (mopen[vch]) merr = 1'b1;
          mopen[vch] = 1'b0;
        end
        3: if (!mopen[vch]) merr = 1'b1;
        2: begin
          if (!mopen[vch]) merr = 1'b1;
          mopen[vch] = 1'b0;
        end
        default: merr = 1'b1;
      endcase
    end
    expv = {msnd, e.v, e.f, CNTW'(mq.size()), merr,
            mq.size() < DEPTH};
    #1;
    l.ivalid = 1'b0;
    l.icredit = 1'b0;
  endtask

  task automatic test_reset;
    bit acc;
    do_reset();
    obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
    total++;
    if (obs !== rstv) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", obs, rstv);
    end
    step(0, 0, '0, 0, 0, acc);
    obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL reset_idle got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_headtail;
    bit acc;
    logic [DATAW-1:0] p;
    do_reset();
    p = rnd64();
    step(1, 0, mk(FT_HEADTAIL, p), 0, 0, acc);
    obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL ht_push got=%h want=%h", obs, expv);
    end
    step(0, 0, '0, 0, 0, acc);
    total++;
    if (l.ovalid !== 1'b1 || l.odata !== mk(FT_HEADTAIL, p)) begin
      bad++;
      $display("FAIL ht_send got=%b/%h want=1/%h",
               l.ovalid, l.odata, mk(FT_HEADTAIL, p));
    end
    // one return refills VC0 to 4, a second one overflows
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, k < 2, 0, acc);
      obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL ht_credit%0d got=%h want=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_long_packet;
    bit acc, saw_full;
    int i, cyc, early, nsent, nobs, t;
    bit cr;
    do_reset();
    i = 0; cyc = 0; early = 0; nsent = 0; nobs = 0;
    saw_full = 1'b0;
    while (nsent < 22 && cyc < 200) begin
      t = (i == 0) ? 1 : (i == 21) ? 2 : 3;
      cr = cyc >= 10 && mcred[1] < CREDITS;
      step(i < 22, 1, mk(t, DATAW'(i)), cr, 1, acc);
      if (acc) i++;
      if (msnd) nsent++;
      if (l.ovalid === 1'b1) nobs++;
      if (cyc < 10 && l.ovalid === 1'b1) early++;
      if (cyc < 10 && l.iready === 1'b0) saw_full = 1'b1;
      obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL long_c%0d got=%h want=%h", cyc, obs, expv);
      end
      cyc++;
    end
    total++;
    if (cyc >= 200) begin
      bad++;
      $display("FAIL long_timeout got=%0d want<200", cyc);
    end
    total++;
    if (early !== 4) begin
      bad++;
      $display("FAIL long_early got=%0d want=4", early);
    end
    total++;
    if (saw_full !== 1'b1) begin
      bad++;
      $display("FAIL long_full got=%b want=1", saw_full);
    end
    total++;
    if (nobs !== 22) begin
      bad++;
      $display("FAIL long_count got=%0d want=22", nobs);
    end
  endtask

  task automatic test_hol;
    bit acc;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      if (k < 4)
        step(1, 0, mk(FT_HEADTAIL, DATAW'(k)), 0, 0, acc);
      else if (k == 5)
        step(1, 0, mk(FT_HEADTAIL, 64'hA0), 0, 0, acc);
      else if (k == 6)
        step(1, 1, mk(FT_HEADTAIL, 64'hB1), 0, 0, acc);
      else
        step(0, 0, '0, k == 10, 0, acc);
      obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL hol_c%0d got=%h want=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_credit_same;
    bit acc;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k < 3 || k == 5 || k == 6)
        step(1, 0, mk(FT_HEADTAIL, DATAW'(k + 16)), k == 6, 0, acc);
      else
        step(0, 0, '0, 0, 0, acc);
      obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL same_c%0d got=%h want=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_errors;
    bit acc;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(k == 0, 0, mk(FT_DATA, 64'h5), 0, 0, acc);
      obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL err_data%0d got=%h want=%h", k, obs, expv);
      end
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, k == 0, 1, acc);
      total++;
      if (l.oerr !== 1'b1) begin
        bad++;
        $display("FAIL err_cred%0d got=%b want=1", k, l.oerr);
      end
    end
    do_reset();
    step(1, 1, mk(FT_NONE, 64'h7), 0, 0, acc);
    obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL err_none got=%h want=%h", obs, expv);
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(k < 2, 1, mk(FT_HEAD, DATAW'(k)), 0, 0, acc);
      obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL err_hh%0d got=%h want=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit acc;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 4)
        step(1, 0, mk(FT_HEADTAIL, DATAW'(k)), 0, 0, acc);
      else if (k == 6)
        step(1, 0, mk(FT_HEADTAIL, 64'hC0), 0, 0, acc);
      else if (k == 7)
        step(1, 1, mk(FT_HEAD, 64'hC1), 0, 0, acc);
      else if (k == 8)
        step(1, 1, mk(FT_DATA, 64'hC2), 0, 0, acc);
      else
        step(0, 0, '0, 0, 0, acc);
    end
    obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL mid_queued got=%h want=%h", obs, expv);
    end
    #3 rst_ = 1'b0;
    #1;
    obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
    total++;
    if (obs !== rstv) begin
      bad++;
      $display("FAIL mid_async got=%h want=%h", obs, rstv);
    end
    #2 rst_ = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      step(k == 0, 1, mk(FT_DATA, 64'hD0), 0, 0, acc);
      obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
      total++;
      if (obs !== expv || l.oerr !== 1'b1) begin
        bad++;
        $display("FAIL mid_after%0d got=%h want=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_random;
    bit acc, have, cr;
    bit gopen[NVC];
    int pv, pt, crv;
    logic [FW-1:0] pf;
    do_reset();
    have = 1'b0; pv = 0; pt = 0; pf = '0;
    for (int v = 0; v < NVC; v++) gopen[v] = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!have && ($urandom % 3) != 0) begin
        pv = int'($urandom_range(0, NVC - 1));
        if (gopen[pv]) pt = ($urandom % 3 == 0) ? 2 : 3;
        else pt = ($urandom % 2 == 0) ? 1 : 4;
        pf = mk(pt, rnd64());
        have = 1'b1;
      end
      crv = int'($urandom_range(0, NVC - 1));
      cr = ($urandom % 2 == 0) && mcred[crv] < CREDITS;
      step(have, pv, pf, cr, crv, acc);
      if (acc) begin
        gopen[pv] = (pt == 1 || pt == 3);
        have = 1'b0;
      end
      obs = {l.ovalid, l.ovch, l.odata, l.ocount, l.oerr, l.iready};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL rand_c%0d got=%h want=%h", k, obs, expv);
      end
    end
  endtask

  initial begin
    rstv = {{(OW-1){1'b0}}, 1'b1};
    model_reset();
    l.ivalid = 1'b0;
    l.idata = '0;
    l.ivch = '0;
    l.icredit = 1'b0;
    l.icredit_vch = '0;
    test_reset();
    test_headtail();
    test_long_packet();
    test_hol();
    test_credit_same();
    test_errors();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
